// File: rtl/led_pkg.sv
// Shared definitions for the LED strip transmitter: state encoding, frame
// geometry and the default NZR timing for a 100 MHz clock.
package led_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SEND  = 2'd1,
    ST_LATCH = 2'd2
  } state_e;

  localparam int NUM_LEDS   = 5;
  localparam int LED_BITS   = 24;
  localparam int FRAME_BITS = NUM_LEDS * LED_BITS;  // 120
  localparam int BIT_CNT_W  = 7;                    // indexes 0..119

  // Default timing in clk cycles at 100 MHz.
  localparam int DEF_T0H  = 40;    // 0.40 us
  localparam int DEF_T1H  = 80;    // 0.80 us
  localparam int DEF_TBIT = 125;   // 1.25 us
  localparam int DEF_TRST = 6000;  // 60 us

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/nzr_bit_gen.sv
// Phase counter for one NZR bit slot plus the high/low decision for the
// current phase. The slot length is TBIT cycles; the line is high for the
// first T1H (bit=1) or T0H (bit=0) cycles of the slot.
module nzr_bit_gen
  import led_pkg::*;
#(
  parameter int T0H  = DEF_T0H,
  parameter int T1H  = DEF_T1H,
  parameter int TBIT = DEF_TBIT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear_i,       // restart at phase 0 (frame capture)
  input  logic run_i,         // advance while a frame is being sent
  input  logic bit_i,         // data bit of the current slot
  output logic level_o,       // line level for the current phase
  output logic last_phase_o   // current phase is TBIT-1
);

  localparam int PW = cnt_width(TBIT);
  localparam logic [PW-1:0] PH_LAST = PW'(TBIT - 1);
  localparam logic [PW-1:0] HI_0    = PW'(T0H);
  localparam logic [PW-1:0] HI_1    = PW'(T1H);

  logic [PW-1:0] phase_q, phase_d;

  // Next phase: clear on capture, otherwise wrap TBIT-1 -> 0 while running.
  always_comb begin
    // NOTE: every variable assigned in always_comb gets a default first so no
    // path leaves it unassigned, which would infer a latch.
    phase_d = phase_q;
    if (clear_i) begin
      phase_d = '0;
    end else if (run_i) begin
      phase_d = (phase_q == PH_LAST) ? '0 : phase_q + PW'(1);
    end
  end

  // Phase register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values, independent of statement order.
    if (!rst_n) begin
      phase_q <= '0;
    end else begin
      phase_q <= phase_d;
    end
  end

  assign level_o      = run_i & (phase_q < (bit_i ? HI_1 : HI_0));
  assign last_phase_o = (phase_q == PH_LAST);

endmodule

// File: rtl/led_strip_tx.sv
// Single-wire NZR transmitter for a 5-LED GRB strip. A Refresh request
// snapshots GRBSeq into a shadow register, sends its 120 bits MSB-first,
// then holds the line low for TRST cycles to latch the strip. Requests that
// arrive during a frame or latch are remembered in a one-deep pending flag
// and start the next frame directly at the end of the latch period.
module led_strip_tx
  import led_pkg::*;
#(
  parameter int T0H  = DEF_T0H,
  parameter int T1H  = DEF_T1H,
  parameter int TBIT = DEF_TBIT,
  parameter int TRST = DEF_TRST
) (
  input  logic                  clk,
  input  logic                  reset,    // asynchronous, active-low
  input  logic [FRAME_BITS-1:0] GRBSeq,
  input  logic                  Refresh,
  output logic                  Dout,
  output logic                  Busy,
  output logic                  Done
);

  localparam int LW = cnt_width(TRST);
  localparam logic [LW-1:0]        LATCH_LAST = LW'(TRST - 1);
  localparam logic [BIT_CNT_W-1:0] BIT_LAST   = BIT_CNT_W'(FRAME_BITS - 1);

  state_e                 state_q;
  logic [FRAME_BITS-1:0]  shadow_q;
  logic [BIT_CNT_W-1:0]   bit_cnt_q;
  logic [LW-1:0]          latch_cnt_q;
  logic                   pending_q;
  logic                   dout_q;
  logic                   busy_q;
  logic                   done_q;

  logic cur_bit;
  logic sending;
  logic latch_end;
  logic restart;
  logic capture;
  logic level;
  logic last_phase;

  // Decode the current data bit and the capture conditions.
  always_comb begin
    cur_bit   = shadow_q[BIT_LAST - bit_cnt_q];
    sending   = (state_q == ST_SEND);
    latch_end = (state_q == ST_LATCH) && (latch_cnt_q == LATCH_LAST);
    // A request on the final latch edge merges with any pending one.
    restart   = latch_end && (pending_q || Refresh);
    capture   = ((state_q == ST_IDLE) && Refresh) || restart;
  end

  nzr_bit_gen #(
    .T0H  (T0H),
    .T1H  (T1H),
    .TBIT (TBIT)
  ) u_bit_gen (
    .clk          (clk),
    .rst_n        (reset),
    .clear_i      (capture),
    .run_i        (sending),
    .bit_i        (cur_bit),
    .level_o      (level),
    .last_phase_o (last_phase)
  );

  // Frame sequencer: IDLE -> SEND -> LATCH -> IDLE/SEND, registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      // NOTE: the shadow is a plain register bank (not a RAM), so it is
      // reset along with the rest; a frame can never replay stale data.
      shadow_q    <= '0;
      bit_cnt_q   <= '0;
      latch_cnt_q <= '0;
      pending_q   <= 1'b0;
      dout_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      dout_q <= 1'b0;
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (Refresh) begin
            shadow_q    <= GRBSeq;
            bit_cnt_q   <= '0;
            latch_cnt_q <= '0;
            state_q     <= ST_SEND;
            busy_q      <= 1'b1;
          end
        end

        ST_SEND: begin
          dout_q <= level;
          if (Refresh) begin
            pending_q <= 1'b1;
          end
          if (last_phase) begin
            if (bit_cnt_q == BIT_LAST) begin
              state_q     <= ST_LATCH;
              latch_cnt_q <= '0;
            end else begin
              bit_cnt_q <= bit_cnt_q + BIT_CNT_W'(1);
            end
          end
        end

        ST_LATCH: begin
          if (latch_end) begin
            done_q <= 1'b1;
            if (restart) begin
              pending_q <= 1'b0;
              shadow_q  <= GRBSeq;
              bit_cnt_q <= '0;
              state_q   <= ST_SEND;
            end else begin
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
            end
          end else begin
            latch_cnt_q <= latch_cnt_q + LW'(1);
            if (Refresh) begin
              pending_q <= 1'b1;
            end
          end
        end

        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign Dout = dout_q;
  assign Busy = busy_q;
  assign Done = done_q;

endmodule

// File: tb/tb_led_strip_tx.sv
// Directed bench for led_strip_tx with short timing (T0H=2, T1H=4, TBIT=6,
// TRST=10): one 6-cycle slot per bit, 720-cycle frames, 10-cycle latch.
module tb_led_strip_tx;

  localparam int T0H  = 2;
  localparam int T1H  = 4;
  localparam int TBIT = 6;
  localparam int TRST = 10;

  logic         clk = 1'b0;
  logic         reset;
  logic [119:0] GRBSeq;
  logic         Refresh;
  logic         Dout;
  logic         Busy;
  logic         Done;

  int n_compared   = 0;
  int n_mismatched = 0;
  int done_seen    = 0;

  always #5 clk = ~clk;

  led_strip_tx #(
    .T0H  (T0H),
    .T1H  (T1H),
    .TBIT (TBIT),
    .TRST (TRST)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .GRBSeq  (GRBSeq),
    .Refresh (Refresh),
    .Dout    (Dout),
    .Busy    (Busy),
    .Done    (Done)
  );

  // Advance one edge and sample just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Apply frame and a one-cycle Refresh; returns right after the capture edge.
  task automatic start_frame(input logic [119:0] frame);
    GRBSeq  = frame;
    Refresh = 1'b1;
    step();
    Refresh = 1'b0;
  endtask

  // Check the 120 slots of a frame; caller has just sampled the capture edge.
  // Refresh is driven high at frame cycle refresh_at, or throughout if hold.
  task automatic check_frame(input logic [119:0] frame, input string tag,
                             input int refresh_at, input bit hold);
    logic [5:0] got;
    logic [5:0] exp;
    logic       busy_all;
    int         k;
    for (int slot = 0; slot < 120; slot++) begin
      got      = '0;
      busy_all = 1'b1;
      for (int p = 0; p < TBIT; p++) begin
        step();
        k          = slot * TBIT + p + 1;
        got[5 - p] = Dout;
        busy_all   = busy_all & Busy;
        if (hold) Refresh = 1'b1;
        else      Refresh = (k == refresh_at);
      end
      exp = frame[119 - slot] ? 6'b111100 : 6'b110000;
      n_compared++;
      if (got !== exp || busy_all !== 1'b1) begin
        n_mismatched++;
        $display("FAIL %s slot%0d: dout=%b busy=%b, expected dout=%b busy=1",
                 tag, slot, got, busy_all, exp);
      end
    end
  endtask

  // Check the 10 latch cycles that follow a frame.
  task automatic check_latch(input string tag, input bit restart,
                             input bit drop_refresh);
    logic [9:0] dout_v;
    logic [9:0] done_v;
    logic [9:0] busy_v;
    logic [9:0] busy_exp;
    for (int i = 0; i < TRST; i++) begin
      step();
      dout_v[9 - i] = Dout;
      done_v[9 - i] = Done;
      busy_v[9 - i] = Busy;
      if (i == TRST - 1 && drop_refresh) Refresh = 1'b0;
    end
    busy_exp = restart ? 10'b1111111111 : 10'b1111111110;
    n_compared++;
    if (dout_v !== 10'b0) begin
      n_mismatched++;
      $display("FAIL %s_dout_low: dout=%b expected 0000000000", tag, dout_v);
    end
    n_compared++;
    if (done_v !== 10'b0000000001) begin
      n_mismatched++;
      $display("FAIL %s_done_pulse: done=%b expected 0000000001", tag, done_v);
    end
    n_compared++;
    if (busy_v !== busy_exp) begin
      n_mismatched++;
      $display("FAIL %s_busy: busy=%b expected %b", tag, busy_v, busy_exp);
    end
    if (done_v[0] === 1'b1) done_seen++;
    if (!restart) begin
      step();
      n_compared++;
      if ({Dout, Busy, Done} !== 3'b000) begin
        n_mismatched++;
        $display("FAIL %s_idle_after: dout/busy/done=%b expected 000",
                 tag, {Dout, Busy, Done});
      end
    end
  endtask

  task automatic test_reset();
    reset   = 1'b0;
    Refresh = 1'b0;
    GRBSeq  = '0;
    #2;
    n_compared++;
    if ({Dout, Busy, Done} !== 3'b000) begin
      n_mismatched++;
      $display("FAIL reset_initial: dout/busy/done=%b expected 000", {Dout, Busy, Done});
    end
    Refresh = 1'b1;  // ignored while reset is held
    step();
    step();
    n_compared++;
    if ({Dout, Busy, Done} !== 3'b000) begin
      n_mismatched++;
      $display("FAIL reset_held: dout/busy/done=%b expected 000", {Dout, Busy, Done});
    end
    Refresh = 1'b0;
    reset   = 1'b1;
    step();
    step();
    n_compared++;
    if ({Dout, Busy, Done} !== 3'b000) begin
      n_mismatched++;
      $display("FAIL reset_release_idle: dout/busy/done=%b expected 000", {Dout, Busy, Done});
    end
  endtask

  // Only bit 119 set: slot 0 is a long pulse, the rest short.
  task automatic test_single_frame();
    logic [119:0] f;
    f = {1'b1, 119'b0};
    start_frame(f);
    check_frame(f, "s1_frame", -1, 1'b0);
    check_latch("s2_latch", 1'b0, 1'b0);
  endtask

  // Refresh mid-frame is queued; next frame starts on the Done edge.
  task automatic test_pending();
    logic [119:0] a;
    logic [119:0] b;
    a = {5{24'hA5C396}};
    b = {24'h00FF00, 24'h123456, 24'h800001, 24'hFFFFFF, 24'h000000};
    start_frame(a);
    GRBSeq = b;  // also must not disturb frame a
    check_frame(a, "s3_frame_a", 300, 1'b0);
    check_latch("s3_latch_a", 1'b1, 1'b0);
    check_frame(b, "s3_frame_b", -1, 1'b0);
    check_latch("s3_latch_b", 1'b0, 1'b0);
  endtask

  // GRBSeq changes right after capture; the frame must keep the old value.
  task automatic test_shadow();
    logic [119:0] c;
    c = {5{24'h5A3C69}};
    start_frame(c);
    GRBSeq = {120{1'b1}};
    check_frame(c, "s4_frame", -1, 1'b0);
    check_latch("s4_latch", 1'b0, 1'b0);
  endtask

  // Asynchronous reset mid-frame, then a clean full frame.
  task automatic test_reset_mid_frame();
    logic [119:0] f;
    logic [119:0] g;
    logic [4:0]   idle_v;
    f = {5{24'h3C3C3C}};
    g = {5{24'hC0FFEE}};
    start_frame(f);
    for (int i = 0; i < 199; i++) step();
    @(posedge clk);
    #3;
    n_compared++;
    if (Dout !== 1'b1 || Busy !== 1'b1) begin
      n_mismatched++;
      $display("FAIL s5_pre_reset: dout=%b busy=%b expected 1 1", Dout, Busy);
    end
    reset = 1'b0;
    #1;
    n_compared++;
    if ({Dout, Busy, Done} !== 3'b000) begin
      n_mismatched++;
      $display("FAIL s5_async_reset: dout/busy/done=%b expected 000", {Dout, Busy, Done});
    end
    step();
    step();
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      idle_v[i] = Dout | Busy | Done;
    end
    n_compared++;
    if (idle_v !== 5'b0) begin
      n_mismatched++;
      $display("FAIL s5_no_resume: activity=%b expected 00000", idle_v);
    end
    start_frame(g);
    check_frame(g, "s5_frame", -1, 1'b0);
    check_latch("s5_latch", 1'b0, 1'b0);
  endtask

  // Refresh tied high: three frames back to back, 730-cycle period.
  task automatic test_back_to_back();
    logic [119:0] h;
    h         = {5{24'h81422A}};
    done_seen = 0;
    GRBSeq    = h;
    Refresh   = 1'b1;
    step();
    check_frame(h, "s6_frame1", -1, 1'b1);
    check_latch("s6_latch1", 1'b1, 1'b0);
    check_frame(h, "s6_frame2", -1, 1'b1);
    check_latch("s6_latch2", 1'b1, 1'b1);
    check_frame(h, "s6_frame3", -1, 1'b0);
    check_latch("s6_latch3", 1'b0, 1'b0);
    n_compared++;
    if (done_seen != 3) begin
      n_mismatched++;
      $display("FAIL s6_done_count: saw %0d expected 3", done_seen);
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_pending();
    test_shadow();
    test_reset_mid_frame();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

  // Guard against a stuck simulation.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/led_strip_tx.md
LED_STRIP_TX -- requirements
Module: led_strip_tx

Interface
REQ-001 SHALL have parameter T0H, default 40, the high time of a 0 bit in clk cycles (0.40 us at 100 MHz).
REQ-002 SHALL have parameter T1H, default 80, the high time of a 1 bit in clk cycles (0.80 us).
REQ-003 SHALL have parameter TBIT, default 125, the total bit period in clk cycles (1.25 us); T0H < T1H < TBIT.
REQ-004 SHALL have parameter TRST, default 6000, the low latch time after a frame in clk cycles (60 us).
REQ-005 SHALL have port clk, input, 1 bit: the single system clock; all state changes on its rising edge.
REQ-006 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port GRBSeq, input, 120 bits: frame for 5 LEDs, 24-bit GRB each; LED0 in [119:96], G in the top byte.
REQ-008 SHALL have port Refresh, input, 1 bit: level request to transmit the current GRBSeq.
REQ-009 SHALL have port Dout, output, 1 bit: registered single-wire NZR data line to the LED strip.
REQ-010 SHALL have port Busy, output, 1 bit: high whenever the state is not IDLE.
REQ-011 SHALL have port Done, output, 1 bit: one-cycle pulse at the end of the latch period.

Function
REQ-012 SHALL implement the states IDLE, SEND and LATCH.
REQ-013 IDLE with Refresh=1 at an edge SHALL capture GRBSeq into a 120-bit shadow register, clear the bit and phase counters, and enter SEND.
REQ-014 GRBSeq changes after capture SHALL NOT affect the frame in flight.
REQ-015 SEND SHALL transmit the shadow MSB-first, bit 119 first and bit 0 last, with one bit per TBIT cycles.
REQ-016 Within each bit slot, for phase p = 0..TBIT-1, Dout SHALL be 1 while p < (bit ? T1H : T0H) and 0 otherwise.
REQ-017 Dout SHALL be registered, so the first high cycle appears one clk after the capture edge.
REQ-018 The phase counter SHALL wrap from TBIT-1 to 0 and increment the bit counter (7 bits, range 0..119).
REQ-019 At bit 119 with phase TBIT-1, the block SHALL enter LATCH; a frame therefore lasts 120*TBIT cycles.
REQ-020 LATCH SHALL hold Dout=0 for exactly TRST cycles, then pulse Done for 1 cycle and return to IDLE.
REQ-021 Refresh=1 seen in SEND or LATCH SHALL set a one-deep pending flag; further requests while pending SHALL be merged into it.
REQ-022 At the end of LATCH with pending=1, the block SHALL clear pending, capture GRBSeq on that same edge, pulse Done, and go directly to SEND.
REQ-023 Frames SHALL never overlap or shorten, and a latch gap of at least TRST cycles SHALL always be kept.
REQ-024 Refresh held high continuously SHALL produce back-to-back frames with period 120*TBIT + TRST cycles.
REQ-025 Dout SHALL be 0 in IDLE and LATCH.
REQ-026 Counter widths SHALL be clog2(TBIT) for phase and clog2(TRST) for latch; no counter may overflow for legal parameters.

Reset
REQ-027 reset=0 SHALL asynchronously force state=IDLE, Dout=0, Busy=0, Done=0, pending=0, all counters=0 and shadow=0.
REQ-028 Reset asserted mid-frame SHALL abort the frame immediately with Dout low; after release no partial frame resumes.
REQ-029 After reset release, the first Refresh SHALL start a fresh frame per REQ-013.

Structure
REQ-030 Package led_pkg SHALL hold the state encoding, NUM_LEDS=5, FRAME_BITS=120, and the default timing constants.
REQ-031 The block MAY use one sub-module, nzr_bit_gen (phase counter plus the high/low compare for one bit); the FSM, shadow register and pending flag SHALL stay in led_strip_tx.

Verification (parameters T0H=2, T1H=4, TBIT=6, TRST=10)
REQ-032 Scenario 1: GRBSeq=120'h800000..0 (only bit 119 set), one-cycle Refresh -> first slot high 4 cycles and low 2; the remaining 119 slots high 2 and low 4; total 720 cycles.
REQ-033 Scenario 2: after that frame -> Dout low for 10 cycles, then Done=1 for exactly 1 cycle, Busy falls with Done, and state is IDLE.
REQ-034 Scenario 3: Refresh pulsed at frame cycle 300 -> no disturbance to the current frame; the second frame starts on the Done edge; the gap is exactly 10 low cycles.
REQ-035 Scenario 4: GRBSeq changed to all-ones one cycle after capture -> the transmitted frame matches the captured value.
REQ-036 Scenario 5: reset=0 at frame cycle 200 -> Dout, Busy and Done go to 0 without waiting for clk; after release, Refresh starts a complete 720-cycle frame.
REQ-037 Scenario 6: Refresh tied high for 3 frames -> frame starts at cycles 1, 731 and 1461 after the first edge, and Done pulses 3 times.
